// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake bundle for the seven-segment scan controller.
// The master offers display content and the slave accepts it when ready.
interface seven_seg_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic                  ready;
   logic [4*DIGITS-1:0]   digits_in;
   logic [DIGITS-1:0]     dp_in;
   logic [2:0]            brightness;
   logic                  blank_lz;

   modport master (
      output load,
      output digits_in,
      output dp_in,
      output brightness,
      output blank_lz,
      input  ready
   );

   modport slave (
      input  load,
      input  digits_in,
      input  dp_in,
      input  brightness,
      input  blank_lz,
      output ready
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with PWM brightness.
// Loaded content is staged in a shadow set and applied at frame boundaries.
module seven_seg_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 17500
) (
   input  logic                clk,
   input  logic                rst,
   seven_seg_scan_ctrl_if.slave bus,
   output logic [6:0]          segment,
   output logic                dp,
   output logic [DIGITS-1:0]   anode,
   output logic                frame_done
);
   localparam int CW = $clog2(PRESCALE);
   localparam int PW = $clog2(DIGITS);

   typedef struct packed {
      logic [4*DIGITS-1:0] dig;
      logic [DIGITS-1:0]   dp;
      logic [2:0]          br;
      logic                lz;
   } disp_t;

   typedef enum logic {
      S_IDLE,
      S_PEND
   } st_t;

   logic [CW-1:0]     cnt_q;
   logic [2:0]        ph_q;
   logic [PW-1:0]     pos_q;
   logic              tick;
   logic              last_pos;
   logic              bound;
   logic              bound_q;

   st_t               st_q;
   st_t               st_d;
   logic              take;
   logic              apply;

   disp_t             in_d;
   disp_t             sh_q;
   disp_t             act_q;

   logic [3:0]        nib;
   logic [6:0]        seg_d;
   logic [DIGITS-1:0] blank;
   logic [DIGITS-1:0] sel;
   logic              zrun;

   assign tick     = cnt_q == CW'(PRESCALE - 1);
   assign last_pos = pos_q == PW'(DIGITS - 1);
   assign bound    = tick && (ph_q == 3'd7) && last_pos;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         ph_q  <= '0;
         pos_q <= '0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + CW'(1);
         if (tick) begin
            ph_q <= ph_q + 3'd1;
            if (ph_q == 3'd7) begin
               pos_q <= last_pos ? '0 : pos_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q <= S_IDLE;
      end else begin
         st_q <= st_d;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         S_IDLE: if (bus.load) st_d = S_PEND;
         S_PEND: if (bound) st_d = S_IDLE;
         default: st_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = st_q == S_IDLE;
      take      = (st_q == S_IDLE) && bus.load;
      apply     = (st_q == S_PEND) && bound;
   end

   assign in_d = {bus.digits_in, bus.dp_in, bus.brightness, bus.blank_lz};

   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_q  <= '0;
         act_q <= '0;
      end else begin
         if (take) sh_q <= in_d;
         if (apply) act_q <= sh_q;
      end
   end

   // Blanking runs from the leftmost position down; position 0 always shows.
   always_comb begin
      zrun  = act_q.lz;
      blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zrun     = zrun && (act_q.dig[4*i +: 4] == 4'h0);
         blank[i] = zrun;
      end
   end

   always_comb begin
      nib   = act_q.dig[{pos_q, 2'b00} +: 4];
      seg_d = 7'h00;
      unique case (nib)
         4'h0: seg_d = 7'h3F;
         4'h1: seg_d = 7'h06;
         4'h2: seg_d = 7'h5B;
         4'h3: seg_d = 7'h4F;
         4'h4: seg_d = 7'h66;
         4'h5: seg_d = 7'h6D;
         4'h6: seg_d = 7'h7D;
         4'h7: seg_d = 7'h07;
         4'h8: seg_d = 7'h7F;
         4'h9: seg_d = 7'h6F;
         4'hA: seg_d = 7'h77;
         4'hB: seg_d = 7'h7C;
         4'hC: seg_d = 7'h39;
         4'hD: seg_d = 7'h5E;
         4'hE: seg_d = 7'h79;
         4'hF: seg_d = 7'h71;
      endcase
   end

   assign sel = DIGITS'(1) << pos_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         segment    <= '0;
         dp         <= 1'b0;
         anode      <= '0;
         bound_q    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         segment    <= blank[pos_q] ? 7'h00 : seg_d;
         dp         <= act_q.dp[pos_q];
         anode      <= (ph_q <= act_q.br) ? sel : '0;
         bound_q    <= bound;
         frame_done <= bound_q;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a time-indexed
// reference of the scan sequence and frame-boundary content swaps.
module tb_seven_seg_scan_ctrl;
   localparam int D     = 4;
   localparam int P     = 4;
   localparam int SLOT  = 8 * P;
   localparam int FRAME = D * SLOT;

   typedef struct packed {
      logic [4*D-1:0] dig;
      logic [D-1:0]   dp;
      logic [2:0]     br;
      logic           lz;
   } word_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [6:0]     segment;
   logic           dp;
   logic [D-1:0]   anode;
   logic           frame_done;

   seven_seg_scan_ctrl_if #(.DIGITS(D)) bus ();

   seven_seg_scan_ctrl #(
      .DIGITS   (D),
      .PRESCALE (P)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .segment    (segment),
      .dp         (dp),
      .anode      (anode),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tbl [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   word_t        act;
   word_t        sh;
   bit           pend;
   int           n;
   logic [6:0]   e_seg;
   logic         e_dp;
   logic [D-1:0] e_an;
   logic         e_fd;
   int           n_cmp = 0;
   int           n_err = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // n is the count of clocks since reset; outputs after an edge show slot n.
   task automatic model_edge(bit r, bit ld, word_t w);
      int pos;
      int ph;
      int nb;
      int hi;
      if (!r) begin
         e_seg = '0;
         e_dp  = 1'b0;
         e_an  = '0;
         e_fd  = 1'b0;
         n     = 0;
         act   = '0;
         sh    = '0;
         pend  = 1'b0;
         return;
      end
      pos = (n / SLOT) % D;
      ph  = (n / P) % 8;
      nb  = int'((act.dig >> (4 * pos)) & 16'hF);
      hi  = 0;
      for (int i = 0; i < D; i++) begin
         if (((act.dig >> (4 * i)) & 16'hF) != 0) hi = i;
      end
      e_seg = (act.lz && pos > hi) ? 7'h00 : hex_tbl[nb];
      e_dp  = act.dp[pos];
      e_an  = (ph <= int'(act.br)) ? D'(1 << pos) : '0;
      e_fd  = (n > 0) && (n % FRAME == 0);
      if ((n % FRAME == FRAME - 1) && pend) begin
         act  = sh;
         pend = 1'b0;
      end else if (ld && !pend) begin
         sh   = w;
         pend = 1'b1;
      end
      n++;
   endtask

   task automatic cyc(bit r, bit ld, word_t w);
      rst            = r;
      bus.load       = ld;
      bus.digits_in  = w.dig;
      bus.dp_in      = w.dp;
      bus.brightness = w.br;
      bus.blank_lz   = w.lz;
      @(posedge clk);
      model_edge(r, ld, w);
      #1;
      chk("anode", 32'(anode), 32'(e_an));
      chk("segment", 32'(segment), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("ready", 32'(bus.ready), 32'(!pend));
      chk("onehot", 32'($countones(anode) <= 1), 32'd1);
      @(negedge clk);
   endtask

   function automatic word_t rnd_word();
      word_t w;
      w.dig = 16'($urandom);
      w.dp  = 4'($urandom);
      w.br  = 3'($urandom);
      w.lz  = 1'($urandom);
      return w;
   endfunction

   task automatic idle(int k);
      for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, rnd_word());
   endtask

   initial begin
      word_t w;
      int    k;
      bus.load       = 1'b0;
      bus.digits_in  = '0;
      bus.dp_in      = '0;
      bus.brightness = '0;
      bus.blank_lz   = 1'b0;
      @(negedge clk);
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, rnd_word());

      cyc(1'b1, 1'b0, '0);
      chk("first_anode", 32'(anode), 32'h1);
      chk("first_segment", 32'(segment), 32'h3F);
      idle(FRAME + 20);

      w = '{dig: 16'h12AF, dp: 4'b0100, br: 3'd7, lz: 1'b0};
      cyc(1'b1, 1'b1, w);
      chk("ready_drop", 32'(bus.ready), 32'd0);
      idle(2 * FRAME);

      w = '{dig: 16'h0030, dp: 4'b0000, br: 3'd7, lz: 1'b1};
      cyc(1'b1, 1'b1, w);
      idle(2 * FRAME);
      w = '{dig: 16'h0000, dp: 4'b0000, br: 3'd5, lz: 1'b1};
      cyc(1'b1, 1'b1, w);
      idle(2 * FRAME);

      for (int i = 0; i < 3 * FRAME; i++) cyc(1'b1, 1'b1, rnd_word());
      idle(FRAME);

      k = 0;
      while (!((n % FRAME == FRAME - 1) && !pend) && k < 3 * FRAME) begin
         idle(1);
         k++;
      end
      chk("bound_wait", 32'(k < 3 * FRAME), 32'd1);
      w = '{dig: 16'h8E5C, dp: 4'b1001, br: 3'd3, lz: 1'b0};
      cyc(1'b1, 1'b1, w);
      chk("bound_pend", 32'(bus.ready), 32'd0);
      idle(2 * FRAME + 5);

      w = '{dig: 16'h7B46, dp: 4'b0011, br: 3'd6, lz: 1'b0};
      cyc(1'b1, 1'b1, w);
      idle(13);
      cyc(1'b0, 1'b0, rnd_word());
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_anode", 32'(anode), 32'd0);
      idle(2 * FRAME);

      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 999) != 0, $urandom_range(0, 39) == 0, rnd_word());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
